display_scan_decoder: RTL and testbench

Receive-side counterpart of the multiplexed hex display driver. The block samples a time-multiplexed 4-digit 7-segment bus (active-low segments a..g, active-low digit selects s0..s3) and turns it back into four 4-bit hex values. It flags malformed patterns, reports when a full scan frame has completed, and reports digits that have stopped refreshing. It sits on the FPGA loopback or test header, watching the display pins, and is used for self-check and verification of display drivers.

---
 rtl/display_scan_decoder_if.sv | 32 +++
 rtl/display_scan_decoder.sv | 222 ++++++++++++++++++++++
 tb/tb_display_scan_decoder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_decoder_if.sv
// Display bus seen on the pins of a multiplexed 4-digit 7-segment display.
//
// Signals (all active-low):
//   a..g    segment lines. The segment vector is {a,b,c,d,e,f,g}, with a as the MSB.
//   s0..s3  digit selects. The select vector is {s3,s2,s1,s0}.
//
// Modports:
//   master  the display driver, or a bench standing in for one
//   slave   the scan decoder watching the pins
interface display_scan_decoder_if;
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
    logic s0;
    logic s1;
    logic s2;
    logic s3;

    modport master (
        output a, b, c, d, e, f, g,
        output s0, s1, s2, s3
    );

    modport slave (
        input a, b, c, d, e, f, g,
        input s0, s1, s2, s3
    );
endinterface

// File: rtl/display_scan_decoder.sv
// display_scan_decoder
//
// Watches a time-multiplexed 4-digit 7-segment bus and recovers the four hex
// values being displayed. A pattern is captured only after it has held still
// for STABLE_CYCLES synchronized samples. Each held pattern (one dwell) gives
// exactly one capture.
//
// Ports:
//   Clock                 system clock, rising edge
//   Reset_n               asynchronous active-low reset
//   bus (slave)           segment lines a..g and selects s0..s3, all active-low
//   digit0..digit3 [3:0]  last correctly decoded value for each digit
//   valid [3:0]           bit N: digitN holds a fresh, legal value
//   stale [3:0]           bit N: digit N has not been refreshed in TIMEOUT_CYCLES
//   error                 one-cycle pulse on an illegal captured pattern
//   frame                 one-cycle pulse when all four digits have been seen
//
// Parameters:
//   STABLE_CYCLES   identical samples needed before a capture (must be >= 2)
//   TIMEOUT_CYCLES  cycles without a good capture before a digit is stale
module display_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    display_scan_decoder_if.slave  bus,
    output logic [3:0]             digit0,
    output logic [3:0]             digit1,
    output logic [3:0]             digit2,
    output logic [3:0]             digit3,
    output logic [3:0]             valid,
    output logic [3:0]             stale,
    output logic                   error,
    output logic                   frame
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX   = TW'(TIMEOUT_CYCLES);

    // Pin vector is {a,b,c,d,e,f,g,s3,s2,s1,s0}.
    logic [10:0]   pin_raw;
    logic [10:0]   sync1;
    logic [10:0]   sync2;
    logic [10:0]   prev;
    logic [SW-1:0] stab_cnt;
    logic          capture;

    logic [6:0]    seg_cap;
    logic [3:0]    sel_cap;
    logic          sel_ok;
    logic          sel_idle;
    logic [1:0]    sel_idx;
    logic [3:0]    sel_hot;
    logic          seg_ok;
    logic [3:0]    seg_val;
    logic          good;
    logic          bad_seg;
    logic          bad_sel;
    logic [3:0]    seen;
    logic [3:0]    seen_next;
    logic          frame_hit;

    logic [3:0]    digit_q [4];
    logic [TW-1:0] timer   [4];
    logic [3:0]    valid_q;
    logic [3:0]    stale_q;
    logic          error_q;
    logic          frame_q;

    assign pin_raw = {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g,
                      bus.s3, bus.s2, bus.s1, bus.s0};

    // Two-flop synchronizer, plus one more register holding the previous
    // synchronized sample for the stability compare. All of them reset to
    // ones (the blank/idle pattern), so a reset looks like an idle bus
    // rather than a pattern change.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= pin_raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // The counter saturates at STABLE_CYCLES, so a long dwell captures only
    // once. The capture is decoded one cycle early (counter about to reach
    // STABLE_CYCLES) so the outputs update on the same edge as the counter.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            stab_cnt <= '0;
        end else if (sync2 != prev) begin
            stab_cnt <= '0;
        end else if (stab_cnt != STABLE_MAX) begin
            stab_cnt <= stab_cnt + SW'(1);
        end
    end

    assign capture = (sync2 == prev) && (stab_cnt == STABLE_LAST);

    // Active-low segment pattern {a..g} to hex nibble. The MSB of the result
    // is set when the pattern is one of the sixteen legal glyphs.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h01:   r = {1'b1, 4'h0};
            7'h4F:   r = {1'b1, 4'h1};
            7'h12:   r = {1'b1, 4'h2};
            7'h06:   r = {1'b1, 4'h3};
            7'h4C:   r = {1'b1, 4'h4};
            7'h24:   r = {1'b1, 4'h5};
            7'h20:   r = {1'b1, 4'h6};
            7'h0F:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h04:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h60:   r = {1'b1, 4'hB};
            7'h31:   r = {1'b1, 4'hC};
            7'h42:   r = {1'b1, 4'hD};
            7'h30:   r = {1'b1, 4'hE};
            7'h38:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    assign seg_cap = sync2[10:4];
    assign sel_cap = sync2[3:0];

    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (sel_cap)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    assign sel_idle           = (sel_cap == 4'b1111);
    assign {seg_ok, seg_val}  = seg_decode(seg_cap);
    assign sel_hot            = 4'b0001 << sel_idx;

    // An idle select never counts as an error. Only a single-digit select
    // with a bad glyph, or a select that is neither idle nor one-cold, does.
    assign good      = capture && sel_ok && seg_ok;
    assign bad_seg   = capture && sel_ok && !seg_ok;
    assign bad_sel   = capture && !sel_ok && !sel_idle;
    assign seen_next = seen | sel_hot;
    assign frame_hit = good && (seen_next == 4'b1111);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            seen    <= '0;
            error_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            error_q <= bad_seg || bad_sel;
            frame_q <= frame_hit;
            if (frame_hit) begin
                seen <= '0;
            end else if (good) begin
                seen <= seen_next;
            end
        end
    end

    // Per-digit state. A good capture takes priority over a timeout that
    // lands on the same edge. A bad glyph only drops valid. The timer keeps
    // running, so staleness still counts from the last good capture.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int n = 0; n < 4; n++) begin
                digit_q[n] <= '0;
                timer[n]   <= '0;
            end
            valid_q <= '0;
            stale_q <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (good && (sel_idx == 2'(n))) begin
                    digit_q[n] <= seg_val;
                    valid_q[n] <= 1'b1;
                    stale_q[n] <= 1'b0;
                    timer[n]   <= '0;
                end else begin
                    if (timer[n] != TIMER_MAX) begin
                        timer[n] <= timer[n] + TW'(1);
                    end
                    if (timer[n] == TIMER_LAST) begin
                        stale_q[n] <= 1'b1;
                        valid_q[n] <= 1'b0;
                    end
                    if (bad_seg && (sel_idx == 2'(n))) begin
                        valid_q[n] <= 1'b0;
                    end
                end
            end
        end
    end

    assign digit0 = digit_q[0];
    assign digit1 = digit_q[1];
    assign digit2 = digit_q[2];
    assign digit3 = digit_q[3];
    assign valid  = valid_q;
    assign stale  = stale_q;
    assign error  = error_q;
    assign frame  = frame_q;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Bench for display_scan_decoder. It runs with STABLE_CYCLES=16 and
// TIMEOUT_CYCLES=1000.
//
// A behavioural model works from the pin history: the two-edge pipeline
// delay, the run length of identical samples, table lookups, and the number
// of edges since the last good capture. It is checked against the DUT on
// every falling edge. Directed literal checks pin the model's timing.
module tb_display_scan_decoder;

    localparam int S = 16;
    localparam int T = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg = 7'h7F;
    logic [3:0] sel = 4'hF;

    logic [3:0] digit0, digit1, digit2, digit3, valid, stale;
    logic       error, frame;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int frm_cnt = 0;

    display_scan_decoder_if bus ();

    assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg;
    assign {bus.s3, bus.s2, bus.s1, bus.s0} = sel;

    display_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus),
        .digit0  (digit0),
        .digit1  (digit1),
        .digit2  (digit2),
        .digit3  (digit3),
        .valid   (valid),
        .stale   (stale),
        .error   (error),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0]  seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                  7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    logic [10:0] mq0 = '1, mq1 = '1, mlast = '1;
    int          run = 1;
    int          ecnt = 0;
    int          m_last [4] = '{0, 0, 0, 0};
    logic [3:0]  m_digit [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  m_valid_f = '0;
    logic [3:0]  m_seen = '0;
    logic        m_err = 1'b0;
    logic        m_frm = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [10:0] vis;
        int          idx;
        int          val;
        if (!rst_n) begin
            mq0 = '1; mq1 = '1; mlast = '1; run = 1; ecnt = 0;
            for (int n = 0; n < 4; n++) begin
                m_last[n]  = 0;
                m_digit[n] = 4'h0;
            end
            m_valid_f = '0; m_seen = '0; m_err = 1'b0; m_frm = 1'b0;
        end else begin
            ecnt++;
            vis = mq0;
            mq0 = mq1;
            mq1 = {seg, sel};
            if (vis == mlast) run++;
            else run = 1;
            mlast = vis;
            m_err = 1'b0;
            m_frm = 1'b0;
            if (run == S + 1) begin
                case (vis[3:0])
                    4'hE: idx = 0;
                    4'hD: idx = 1;
                    4'hB: idx = 2;
                    4'h7: idx = 3;
                    default: idx = -1;
                endcase
                val = -1;
                for (int k = 0; k < 16; k++)
                    if (seg_tab[k] == vis[10:4]) val = k;
                if (idx >= 0) begin
                    if (val >= 0) begin
                        m_digit[idx]   = 4'(val);
                        m_valid_f[idx] = 1'b1;
                        m_last[idx]    = ecnt;
                        m_seen[idx]    = 1'b1;
                        if (m_seen == 4'hF) begin
                            m_frm  = 1'b1;
                            m_seen = '0;
                        end
                    end else begin
                        m_err          = 1'b1;
                        m_valid_f[idx] = 1'b0;
                    end
                end else if (vis[3:0] != 4'hF) begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [3:0] dd [4];
        logic [3:0] exp_stale;
        dd[0] = digit0; dd[1] = digit1; dd[2] = digit2; dd[3] = digit3;
        for (int n = 0; n < 4; n++) begin
            exp_stale[n] = (ecnt - m_last[n]) >= T;
            chk($sformatf("model_digit%0d", n), 32'(dd[n]), 32'(m_digit[n]));
        end
        chk("model_stale", 32'(stale), 32'(exp_stale));
        chk("model_valid", 32'(valid), 32'(m_valid_f & ~exp_stale));
        chk("model_error", 32'(error), 32'(m_err));
        chk("model_frame", 32'(frame), 32'(m_frm));
        if (error) err_cnt++;
        if (frame) frm_cnt++;
    end

    // ---------------- directed stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] s, input logic [6:0] sg, input int n);
        sel = s;
        seg = sg;
        cycles(n);
    endtask

    initial begin
        cycles(3);
        // Release reset and present digit 0 = 2 on the same falling edge.
        rst_n = 1'b1;
        drive(4'hE, 7'h12, 18);
        chk("first_capture_not_early", 32'(valid), 32'h0);
        cycles(1);
        chk("first_capture_valid", 32'(valid), 32'h1);
        chk("first_capture_digit0", 32'(digit0), 32'h2);
        cycles(200);
        chk("hold_no_error", 32'(err_cnt), 32'd0);
        chk("hold_no_frame", 32'(frm_cnt), 32'd0);

        // Glitching pattern faster than the stability window.
        for (int i = 0; i < 50; i++) drive(4'hD, (i % 2 == 0) ? 7'h06 : 7'h12, 10);
        chk("glitch_no_error", 32'(err_cnt), 32'd0);
        chk("glitch_valid1", 32'(valid[1]), 32'd0);

        // Two full scans: 3, A, F, 0.
        for (int p = 0; p < 2; p++) begin
            drive(4'hE, 7'h06, 100);
            drive(4'hD, 7'h08, 100);
            drive(4'hB, 7'h38, 100);
            drive(4'h7, 7'h01, 100);
            chk($sformatf("scan%0d_frames", p), 32'(frm_cnt), 32'(p + 1));
        end
        chk("scan_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h0FA3);
        chk("scan_valid", 32'(valid), 32'hF);

        // Illegal select, then idle.
        drive(4'hC, 7'h01, 100);
        chk("badsel_error", 32'(err_cnt), 32'd1);
        chk("badsel_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h0FA3);
        chk("badsel_valid", 32'(valid), 32'hF);
        drive(4'hF, 7'h01, 100);
        chk("idle_no_error", 32'(err_cnt), 32'd1);

        // Digit 2 = 5, then an illegal glyph on digit 2.
        drive(4'hB, 7'h24, 100);
        chk("d2_digit", 32'(digit2), 32'h5);
        chk("d2_valid", 32'(valid[2]), 32'd1);
        drive(4'hB, 7'h7F, 100);
        chk("d2_bad_error", 32'(err_cnt), 32'd2);
        chk("d2_bad_valid", 32'(valid[2]), 32'd0);
        chk("d2_bad_held", 32'(digit2), 32'h5);

        // Staleness: capture digit 1, then stop refreshing it.
        drive(4'hD, 7'h4F, 19);
        chk("stale_cap_valid", 32'(valid[1]), 32'd1);
        chk("stale_cap_digit", 32'(digit1), 32'h1);
        drive(4'hF, 7'h7F, 999);
        chk("stale_not_early", 32'(stale[1]), 32'd0);
        cycles(1);
        chk("stale_set", 32'(stale[1]), 32'd1);
        chk("stale_valid_clr", 32'(valid[1]), 32'd0);
        chk("stale_digit_held", 32'(digit1), 32'h1);

        // Reset in the middle of a dwell on digit 3.
        drive(4'h7, 7'h00, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h0);
        chk("rst_flags", {22'h0, valid, stale, error, frame}, 32'h0);
        cycles(2);
        rst_n = 1'b1;
        cycles(18);
        chk("rst_no_early_capture", 32'(valid), 32'h0);
        cycles(1);
        chk("rst_capture_valid", 32'(valid), 32'h8);
        chk("rst_capture_digit3", 32'(digit3), 32'h8);
        cycles(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
